zmaps_rd: RTL and testbench
===========================

Name: zmaps_rd

Overview:
- Read-side counterpart of the FPGA-RAM memory map (CRAM, SFILE).
- Serves Z80 memory reads that hit the FMAPS window, plus DMA readback requests.
- Issues word reads to the CRAM/SFILE read ports and waits out a fixed RAM latency.
- Returns the selected byte to the Z80 data mux, or the full 16-bit word to DMA.
- Sits beside the write mapper in the z80 subsystem and shares its window decode rules.

Parameters:
- RAM_LAT, 1, CRAM/SFILE read latency in clk cycles (1..3), from read-enable to data valid.
- RD_FILL, 8'hFF, byte returned for in-window reads outside CRAM/SFILE (REGS and unmapped).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- memrd_s  in  1  Z80 memory-read strobe, one-cycle pulse per read
- a  in  16  Z80 address
- fmaddr  in  5  window config: [4] enable, [3:0] = a[15:12] match
- zrd_hit  out  1  combinational; memrd_s && window hit, steers the Z80 data mux
- zrd_data  out  8  byte returned to the Z80
- zrd_valid  out  1  one-cycle pulse, zrd_data valid
- dma_rd_req  in  1  DMA read request, held until dma_rd_ack
- dma_rd_sel  in  1  0 = CRAM, 1 = SFILE
- dma_rdaddr  in  8  DMA word address
- dma_rd_ack  out  1  one-cycle accept pulse
- dma_rd_data  out  16  word returned to DMA
- dma_rd_valid  out  1  one-cycle pulse, dma_rd_data valid
- ram_ra  out  8  shared CRAM/SFILE read word address
- cram_re  out  1  CRAM read enable, one cycle
- sfile_re  out  1  SFILE read enable, one cycle
- cram_rd  in  16  CRAM read data
- sfile_rd  in  16  SFILE read data

Behaviour:
- Window decode (same rules as the write side):
  - hit = fmaddr[4] && a[15:12] == fmaddr[3:0] && memrd_s.
  - CRAM when a[11:9] = 3'b000; SFILE when a[11:9] = 3'b001.
  - Word address = a[8:1]; byte select = a[0] (0 = low byte [7:0], 1 = high byte [15:8]).
- FSM states: IDLE, ISSUE, WAIT, DONE. Reset state is IDLE.
- All outputs reset to 0: zrd_data, zrd_valid, dma_rd_ack, dma_rd_data, dma_rd_valid, ram_ra, cram_re, sfile_re.
- IDLE:
  - Z80 hit on CRAM/SFILE: latch word address, target and byte select; go to ISSUE.
  - Z80 hit on any other window address: go to DONE with zrd_data = RD_FILL and no RAM access.
  - Otherwise, if dma_rd_req: pulse dma_rd_ack, latch dma_rd_sel and dma_rdaddr; go to ISSUE.
- ISSUE (1 cycle):
  - Drive ram_ra with the latched address.
  - Assert cram_re or sfile_re (never both); load the latency counter with RAM_LAT-1.
  - Go to WAIT, or to DONE directly when RAM_LAT = 1.
- WAIT: decrement the counter each cycle; go to DONE when it reaches 0.
- DONE (1 cycle):
  - Sample the selected read bus.
  - Z80 owner: zrd_data = selected byte; zrd_valid pulses.
  - DMA owner: dma_rd_data = full word; dma_rd_valid pulses.
  - Return to IDLE.
- Latency: memrd_s to zrd_valid is RAM_LAT+1 cycles (2 with default), or 1 cycle for RD_FILL reads.
- Arbitration: Z80 has fixed priority over DMA. A simultaneous Z80 hit and dma_rd_req in IDLE serves the Z80 first; DMA stays pending, with no ack until IDLE is re-entered.
- A memrd_s hit arriving while busy:
  - It is queued in a one-deep pending register and served next from IDLE, ahead of DMA.
  - A second hit while the pending register is full is dropped and flagged by an assertion (illegal; Z80 strobe spacing guarantees at least 3 clk).
- Data outputs hold their last value between valid pulses.
- Reset mid-operation: FSM returns to IDLE, pending is cleared, no valid or ack pulse is emitted.
- zrd_hit is purely combinational and is not affected by FSM state.

Optional Feature:
- Macro: ZMAPS_RD_CACHE_EN.
- With the macro:
  - Keep a word latch tagged with {target, word address, tag_valid}, loaded on every Z80 DONE.
  - A Z80 hit matching the tag goes straight to DONE and returns the byte from the latch, with no RAM access (1-cycle latency).
  - Any DMA read, or any write strobe on the matching word (input zmaps_we, present only with the macro), clears tag_valid.
  - Reset clears tag_valid.
- Without the macro: every CRAM/SFILE read accesses RAM, and the zmaps_we port is absent.

Decomposition:
- Shared package zmaps_pkg:
  - window region constants CRAM = 3'b000, SFIL = 3'b001, REGS = 4'b0100;
  - FSM state encoding;
  - owner enum (Z80, DMA).
- The write mapper imports the same region constants.
- One natural sub-module, zmaps_rd_lat: the latency counter with load/done, sized from RAM_LAT.

Test Plan:
- Z80 read: fmaddr = 5'h1F, a = 16'hF003, cram_rd = 16'hA55A at latency → zrd_hit = 1; cram_re at cycle 1 with ram_ra = 8'h01; zrd_valid at cycle 2 with zrd_data = 8'hA5; sfile_re stays 0.
- Z80 read of REGS area: a = 16'hF801 → zrd_valid after 1 cycle with 8'hFF; no cram_re/sfile_re pulse.
- Simultaneous Z80 SFILE hit and dma_rd_req (CRAM, addr 8'h10) → SFILE served first; dma_rd_ack delayed until IDLE is re-entered; dma_rd_data = the cram_rd value for 8'h10.
- RAM_LAT = 3 → memrd_s to zrd_valid = 4 cycles; exactly one re pulse per access.
- Reset asserted in WAIT → no valid pulse; all outputs 0; the next read completes normally.
- ZMAPS_RD_CACHE_EN: read F000 then F001 → only one cram_re; second byte returned in 1 cycle. Read F000, write F001 (zmaps_we), read F001 → a new cram_re is issued.

Source files
------------

// File: rtl/zmaps_pkg.sv
// Shared FPGA-RAM memory map definitions: window regions, read FSM states,
// request owner and the Z80 window-address decode used by both mappers.
package zmaps_pkg;

    localparam logic [2:0] CRAM = 3'b000;
    localparam logic [2:0] SFIL = 3'b001;
    localparam logic [3:0] REGS = 4'b0100;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef enum logic {
        Z80 = 1'b0,
        DMA = 1'b1
    } owner_t;

    // Decoded Z80 read: ram = CRAM/SFILE target, sel = SFILE, wa = word, bsel = high byte
    typedef struct packed {
        logic       ram;
        logic       sel;
        logic [7:0] wa;
        logic       bsel;
    } zreq_t;

    function automatic zreq_t zdecode(input logic [15:0] addr);
        zreq_t r;
        r.ram  = (addr[11:9] == CRAM) || (addr[11:9] == SFIL);
        r.sel  = (addr[11:9] == SFIL);
        r.wa   = addr[8:1];
        r.bsel = addr[0];
        return r;
    endfunction

endpackage

// File: rtl/zmaps_rd_lat.sv
// RAM read latency counter: loaded with LAT-1 on issue, done_c flags the last wait cycle.
module zmaps_rd_lat
    import zmaps_pkg::*;
#(
    parameter int unsigned LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    output logic done_c
);

    localparam int unsigned CW = (LAT > 1) ? $clog2(LAT) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CW'(LAT - 1);
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - CW'(1);
        end
    end

    // The decrement that takes the count to zero ends the wait
    assign done_c = (cnt == CW'(1));

endmodule

// File: rtl/zmaps_rd.sv
// Read side of the FPGA-RAM memory map: serves Z80 window reads and DMA readback
// from CRAM/SFILE. Optional word cache enabled by ZMAPS_RD_CACHE_EN.
module zmaps_rd
    import zmaps_pkg::*;
#(
    parameter int unsigned RAM_LAT = 1,
    parameter logic [7:0]  RD_FILL = 8'hFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memrd_s,
    input  logic [15:0] a,
    input  logic [4:0]  fmaddr,
`ifdef ZMAPS_RD_CACHE_EN
    input  logic        zmaps_we,
`endif
    output logic        zrd_hit,
    output logic [7:0]  zrd_data,
    output logic        zrd_valid,
    input  logic        dma_rd_req,
    input  logic        dma_rd_sel,
    input  logic [7:0]  dma_rdaddr,
    output logic        dma_rd_ack,
    output logic [15:0] dma_rd_data,
    output logic        dma_rd_valid,
    output logic [7:0]  ram_ra,
    output logic        cram_re,
    output logic        sfile_re,
    input  logic [15:0] cram_rd,
    input  logic [15:0] sfile_rd
);

    state_t      state, nxt;
    owner_t      owner;
    zreq_t       zq, req, pend;
    logic        pend_v;
    logic        win, zreq, go_z, go_dma;
    logic        lat_load, lat_dec, lat_done_c, done_ram;
    logic        cache_hit;
    logic [7:0]  cache_byte;
    logic        iss_sel;
    logic [7:0]  iss_wa;
    logic        cur_sel, cur_bsel;
    logic [15:0] word;

    assign win     = fmaddr[4] && (a[15:12] == fmaddr[3:0]);
    assign zrd_hit = win && memrd_s;
    assign zq      = zdecode(a);

    // A queued hit is always older than the one on the bus, so it goes first
    assign req  = pend_v ? pend : zq;
    assign zreq = pend_v || zrd_hit;

    assign iss_sel  = go_dma ? dma_rd_sel : req.sel;
    assign iss_wa   = go_dma ? dma_rdaddr : req.wa;
    assign word     = cur_sel ? sfile_rd : cram_rd;
    assign done_ram = (nxt == DONE) && ((state == ISSUE) || (state == WAIT));

    zmaps_rd_lat #(.LAT(RAM_LAT)) u_lat (
        .clk    (clk),
        .rst    (rst),
        .load   (lat_load),
        .dec    (lat_dec),
        .done_c (lat_done_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt      = state;
        go_z     = 1'b0;
        go_dma   = 1'b0;
        lat_load = 1'b0;
        lat_dec  = 1'b0;
        case (state)
            IDLE: begin
                if (zreq) begin
                    go_z = 1'b1;
                    nxt  = (req.ram && !cache_hit) ? ISSUE : DONE;
                end else if (dma_rd_req) begin
                    go_dma = 1'b1;
                    nxt    = ISSUE;
                end
            end
            ISSUE: begin
                lat_load = 1'b1;
                nxt      = (RAM_LAT == 1) ? DONE : WAIT;
            end
            WAIT: begin
                lat_dec = 1'b1;
                if (lat_done_c) begin
                    nxt = DONE;
                end
            end
            DONE: begin
                nxt = IDLE;
            end
            default: begin
                nxt = IDLE;
            end
        endcase
    end

    // One-deep queue for a Z80 hit that lands while the FSM is busy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_v <= 1'b0;
            pend   <= '0;
        end else if (state == IDLE) begin
            pend_v <= pend_v && zrd_hit;
            if (pend_v && zrd_hit) begin
                pend <= zq;
            end
        end else if (zrd_hit && !pend_v) begin
            pend_v <= 1'b1;
            pend   <= zq;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner        <= Z80;
            cur_sel      <= 1'b0;
            cur_bsel     <= 1'b0;
            zrd_data     <= '0;
            zrd_valid    <= 1'b0;
            dma_rd_ack   <= 1'b0;
            dma_rd_data  <= '0;
            dma_rd_valid <= 1'b0;
            ram_ra       <= '0;
            cram_re      <= 1'b0;
            sfile_re     <= 1'b0;
        end else begin
            zrd_valid    <= 1'b0;
            dma_rd_ack   <= 1'b0;
            dma_rd_valid <= 1'b0;
            cram_re      <= 1'b0;
            sfile_re     <= 1'b0;
            if (go_z) begin
                owner    <= Z80;
                cur_sel  <= req.sel;
                cur_bsel <= req.bsel;
                if (nxt == DONE) begin
                    zrd_valid <= 1'b1;
                    zrd_data  <= req.ram ? cache_byte : RD_FILL;
                end
            end
            if (go_dma) begin
                owner      <= DMA;
                cur_sel    <= dma_rd_sel;
                cur_bsel   <= 1'b0;
                dma_rd_ack <= 1'b1;
            end
            if ((state == IDLE) && (nxt == ISSUE)) begin
                ram_ra   <= iss_wa;
                cram_re  <= !iss_sel;
                sfile_re <= iss_sel;
            end
            // Read bus is sampled on the edge that enters DONE
            if (done_ram) begin
                if (owner == Z80) begin
                    zrd_valid <= 1'b1;
                    zrd_data  <= cur_bsel ? word[15:8] : word[7:0];
                end else begin
                    dma_rd_valid <= 1'b1;
                    dma_rd_data  <= word;
                end
            end
        end
    end

`ifdef ZMAPS_RD_CACHE_EN
    logic        tag_v, tag_sel, we_hit;
    logic [7:0]  tag_wa;
    logic [15:0] tag_word;

    assign cache_hit  = tag_v && req.ram && (req.sel == tag_sel) && (req.wa == tag_wa);
    assign cache_byte = req.bsel ? tag_word[15:8] : tag_word[7:0];
    assign we_hit     = zmaps_we && win && zq.ram && (zq.sel == tag_sel) && (zq.wa == tag_wa);

    // Invalidation wins over a same-cycle fill
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_v    <= 1'b0;
            tag_sel  <= 1'b0;
            tag_wa   <= '0;
            tag_word <= '0;
        end else begin
            if (done_ram && (owner == Z80)) begin
                tag_v    <= 1'b1;
                tag_sel  <= cur_sel;
                tag_wa   <= ram_ra;
                tag_word <= word;
            end
            if (go_dma || we_hit) begin
                tag_v <= 1'b0;
            end
        end
    end
`else
    assign cache_hit  = 1'b0;
    assign cache_byte = RD_FILL;
`endif

`ifndef SYNTHESIS
    a_no_drop: assert property (@(posedge clk) disable iff (rst)
        !(zrd_hit && pend_v && (state != IDLE)))
        else $error("zmaps_rd: Z80 read dropped, pending slot already full");
`endif

endmodule

// File: tb/tb_zmaps_rd.sv
// Directed bench for zmaps_rd: default-latency instance plus a RAM_LAT=3 instance.
module tb_zmaps_rd;

    logic        clk;
    logic        rst;
    logic        memrd_s, memrd3;
    logic [15:0] a;
    logic [4:0]  fmaddr;
    logic        dma_rd_req, dma_rd_sel;
    logic [7:0]  dma_rdaddr;
`ifdef ZMAPS_RD_CACHE_EN
    logic        zmaps_we;
`endif

    logic        zrd_hit, zrd_valid, dma_rd_ack, dma_rd_valid, cram_re, sfile_re;
    logic [7:0]  zrd_data, ram_ra;
    logic [15:0] dma_rd_data, cram_rd, sfile_rd;

    logic        zrd_hit3, zrd_valid3, dma_rd_ack3, dma_rd_valid3, cram_re3, sfile_re3;
    logic [7:0]  zrd_data3, ram_ra3;
    logic [15:0] dma_rd_data3, cram_rd3, sfile_rd3;

    logic [15:0] cram_mem  [256];
    logic [15:0] sfile_mem [256];
    logic        re3_h1, re3_h2;

    int n_err = 0;
    int n_chk = 0;
    int re_cnt;

    zmaps_rd dut (
        .clk(clk), .rst(rst), .memrd_s(memrd_s), .a(a), .fmaddr(fmaddr),
`ifdef ZMAPS_RD_CACHE_EN
        .zmaps_we(zmaps_we),
`endif
        .zrd_hit(zrd_hit), .zrd_data(zrd_data), .zrd_valid(zrd_valid),
        .dma_rd_req(dma_rd_req), .dma_rd_sel(dma_rd_sel), .dma_rdaddr(dma_rdaddr),
        .dma_rd_ack(dma_rd_ack), .dma_rd_data(dma_rd_data), .dma_rd_valid(dma_rd_valid),
        .ram_ra(ram_ra), .cram_re(cram_re), .sfile_re(sfile_re),
        .cram_rd(cram_rd), .sfile_rd(sfile_rd)
    );

    zmaps_rd #(.RAM_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .memrd_s(memrd3), .a(a), .fmaddr(fmaddr),
`ifdef ZMAPS_RD_CACHE_EN
        .zmaps_we(1'b0),
`endif
        .zrd_hit(zrd_hit3), .zrd_data(zrd_data3), .zrd_valid(zrd_valid3),
        .dma_rd_req(1'b0), .dma_rd_sel(1'b0), .dma_rdaddr(8'h00),
        .dma_rd_ack(dma_rd_ack3), .dma_rd_data(dma_rd_data3), .dma_rd_valid(dma_rd_valid3),
        .ram_ra(ram_ra3), .cram_re(cram_re3), .sfile_re(sfile_re3),
        .cram_rd(cram_rd3), .sfile_rd(sfile_rd3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM models: data is only valid RAM_LAT-1 cycles after the read enable
    assign cram_rd  = cram_re  ? cram_mem[ram_ra]  : 16'h0BAD;
    assign sfile_rd = sfile_re ? sfile_mem[ram_ra] : 16'h0BAD;
    assign cram_rd3  = re3_h2 ? cram_mem[ram_ra3]  : 16'h0BAD;
    assign sfile_rd3 = re3_h2 ? sfile_mem[ram_ra3] : 16'h0BAD;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            re3_h1 <= 1'b0;
            re3_h2 <= 1'b0;
        end else begin
            re3_h1 <= cram_re3 | sfile_re3;
            re3_h2 <= re3_h1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            cram_mem[i]  = 16'h1100 + 16'(i);
            sfile_mem[i] = 16'h2200 + 16'(i);
        end
        cram_mem[0]   = 16'h5A6B;
        cram_mem[1]   = 16'hA55A;
        cram_mem[5]   = 16'hC3D4;
        cram_mem[16]  = 16'h1234;
        sfile_mem[2]  = 16'h7788;
        sfile_mem[34] = 16'hBEEF;

        rst = 1'b1; memrd_s = 1'b0; memrd3 = 1'b0; a = 16'h0000; fmaddr = 5'h1F;
        dma_rd_req = 1'b0; dma_rd_sel = 1'b0; dma_rdaddr = 8'h00;
`ifdef ZMAPS_RD_CACHE_EN
        zmaps_we = 1'b0;
`endif
        tick(); tick();
        check("rst_data", {zrd_data, dma_rd_data}, 0);
        check("rst_ctl", {zrd_valid, dma_rd_ack, dma_rd_valid, ram_ra, cram_re, sfile_re}, 0);
        check("rst3", {zrd_data3, dma_rd_data3, zrd_valid3, dma_rd_ack3, dma_rd_valid3,
                       cram_re3, sfile_re3}, 0);
        rst = 1'b0;
        tick();

        // Window misses: disabled window and wrong high nibble
        fmaddr = 5'h0F; a = 16'hF003; memrd_s = 1'b1; #1;
        check("miss_en", zrd_hit, 0);
        fmaddr = 5'h1F; a = 16'hE003; #1;
        check("miss_nib", zrd_hit, 0);
        tick(); memrd_s = 1'b0;
        check("miss_re", {cram_re, sfile_re}, 0);
        tick();
        check("miss_valid", zrd_valid, 0);

        // CRAM high byte read
        a = 16'hF003; memrd_s = 1'b1; #1;
        check("t1_hit", zrd_hit, 1);
        tick(); memrd_s = 1'b0;
        check("t1_cram_re", cram_re, 1);
        check("t1_ram_ra", ram_ra, 8'h01);
        check("t1_sfile_re", sfile_re, 0);
        check("t1_early", zrd_valid, 0);
        tick();
        check("t1_valid", zrd_valid, 1);
        check("t1_data", zrd_data, 8'hA5);
        check("t1_re_off", cram_re, 0);
        tick();
        check("t1_pulse", zrd_valid, 0);
        check("t1_hold", zrd_data, 8'hA5);

        // REGS area returns the fill byte with no RAM access
        a = 16'hF801; memrd_s = 1'b1; #1;
        check("regs_hit", zrd_hit, 1);
        tick(); memrd_s = 1'b0;
        check("regs_valid", zrd_valid, 1);
        check("regs_data", zrd_data, 8'hFF);
        check("regs_re", {cram_re, sfile_re}, 0);
        tick();
        check("regs_pulse", zrd_valid, 0);

        // Simultaneous Z80 SFILE hit and DMA CRAM request
        a = 16'hF245; memrd_s = 1'b1;
        dma_rd_req = 1'b1; dma_rd_sel = 1'b0; dma_rdaddr = 8'h10;
        tick(); memrd_s = 1'b0;
        check("arb_sfile_re", {sfile_re, cram_re}, 2'b10);
        check("arb_ra", ram_ra, 8'h22);
        check("arb_ack1", dma_rd_ack, 0);
        tick();
        check("arb_zvalid", zrd_valid, 1);
        check("arb_zdata", zrd_data, 8'hBE);
        check("arb_ack2", dma_rd_ack, 0);
        tick();
        check("arb_ack3", dma_rd_ack, 0);
        tick();
        check("arb_ack", dma_rd_ack, 1);
        check("arb_dma_re", {cram_re, sfile_re}, 2'b10);
        check("arb_dma_ra", ram_ra, 8'h10);
        dma_rd_req = 1'b0;
        tick();
        check("arb_dvalid", dma_rd_valid, 1);
        check("arb_ddata", dma_rd_data, 16'h1234);
        check("arb_zhold", zrd_data, 8'hBE);
        tick();
        check("arb_dpulse", {dma_rd_valid, dma_rd_ack}, 0);

        // Second hit while busy is queued and served next
        a = 16'hF003; memrd_s = 1'b1;
        tick(); memrd_s = 1'b0;
        tick();
        check("pend_first", zrd_data, 8'hA5);
        a = 16'hF204; memrd_s = 1'b1;
        tick(); memrd_s = 1'b0;
        check("pend_gap", zrd_valid, 0);
        tick();
        check("pend_re", {sfile_re, cram_re}, 2'b10);
        check("pend_ra", ram_ra, 8'h02);
        tick();
        check("pend_valid", zrd_valid, 1);
        check("pend_data", zrd_data, 8'h88);
        tick();

        // RAM_LAT = 3: four cycles to valid, exactly one read enable
        re_cnt = 0;
        a = 16'hF00A; memrd3 = 1'b1; #1;
        check("l3_hit", zrd_hit3, 1);
        for (int c = 1; c <= 5; c++) begin
            tick();
            memrd3 = 1'b0;
            re_cnt += int'(cram_re3) + int'(sfile_re3);
            if (c == 1) check("l3_ra", ram_ra3, 8'h05);
            if (c == 3) check("l3_early", zrd_valid3, 0);
            if (c == 4) begin
                check("l3_valid", zrd_valid3, 1);
                check("l3_data", zrd_data3, 8'hD4);
            end
        end
        check("l3_re_cnt", re_cnt, 1);

        // Reset while waiting on RAM
        memrd3 = 1'b1;
        tick(); memrd3 = 1'b0;
        tick();
        rst = 1'b1; #1;
        check("mid_rst_ctl", {zrd_valid3, cram_re3, sfile_re3, ram_ra3, dma_rd_ack3}, 0);
        check("mid_rst_data", zrd_data3, 0);
        tick(); rst = 1'b0;
        tick();
        check("mid_rst_nv1", zrd_valid3, 0);
        tick();
        check("mid_rst_nv2", zrd_valid3, 0);
        memrd3 = 1'b1;
        tick(); memrd3 = 1'b0;
        check("post_rst_re", cram_re3, 1);
        tick(); tick();
        check("post_rst_early", zrd_valid3, 0);
        tick();
        check("post_rst_valid", zrd_valid3, 1);
        check("post_rst_data", zrd_data3, 8'hD4);
        tick();

        // Two bytes of one word: cached build serves the second from the latch
        a = 16'hF000; memrd_s = 1'b1;
        tick(); memrd_s = 1'b0;
        tick();
        check("c_first", zrd_data, 8'h6B);
        tick();
        a = 16'hF001; memrd_s = 1'b1;
        tick(); memrd_s = 1'b0;
`ifdef ZMAPS_RD_CACHE_EN
        check("c_hit_valid", zrd_valid, 1);
        check("c_hit_data", zrd_data, 8'h5A);
        check("c_hit_re", cram_re, 0);
        tick(); tick();
        zmaps_we = 1'b1; a = 16'hF001;
        tick(); zmaps_we = 1'b0;
        cram_mem[0] = 16'h9C00;
        a = 16'hF001; memrd_s = 1'b1;
        tick(); memrd_s = 1'b0;
        check("c_inv_re", cram_re, 1);
        tick();
        check("c_inv_valid", zrd_valid, 1);
        check("c_inv_data", zrd_data, 8'h9C);
`else
        check("nc_re", cram_re, 1);
        check("nc_early", zrd_valid, 0);
        tick();
        check("nc_valid", zrd_valid, 1);
        check("nc_data", zrd_data, 8'h5A);
`endif
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
